// File: rtl/dff_bank_arb_pkg.sv
// Shared encodings for the DFF bank arbiter: op codes, FSM states and the
// settle counter width.
package dff_bank_arb_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RESET = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int unsigned SettleCntW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSettle,
        StResp
    } state_e;

endpackage

// File: rtl/dff_bank_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr_i (wrapping) wins. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    valid_o
);

    localparam int unsigned IdxW = $clog2(NREQ);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % NREQ);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Shares one DFF bank between NREQ requesters: arbitrates, drives the bank
// for one cycle, waits SETTLE cycles, then returns the captured bank q.
module dff_bank_arbiter
    import dff_bank_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SETTLE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [2*NREQ-1:0]       req_op_i,
    input  logic [WIDTH*NREQ-1:0]   req_data_i,
    input  logic [WIDTH*NREQ-1:0]   req_mask_i,
    output logic [WIDTH-1:0]        bank_d_o,
    output logic [WIDTH-1:0]        bank_en_o,
    output logic [WIDTH-1:0]        bank_sr_o,
    input  logic [WIDTH-1:0]        bank_q_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [$clog2(NREQ)-1:0] rsp_id_o,
    output logic [WIDTH-1:0]        rsp_q_o,
    output logic                    rsp_err_o,
    output logic                    busy_o
);

    localparam int unsigned IdxW = $clog2(NREQ);

    state_e                state_q, state_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       id_q, id_d;
    logic [1:0]            op_q, op_d;
    logic [SettleCntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      d_q, d_d, en_q, en_d, sr_q, sr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [IdxW-1:0]       rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]      rsp_q_q, rsp_q_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [NREQ-1:0]       win_gnt;
    logic [IdxW-1:0]       win_idx;
    logic                  win_valid;

    logic [1:0]            op_arr   [NREQ];
    logic [WIDTH-1:0]      data_arr [NREQ];
    logic [WIDTH-1:0]      mask_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g]   = req_op_i[2*g +: 2];
        assign data_arr[g] = req_data_i[WIDTH*g +: WIDTH];
        assign mask_arr[g] = req_mask_i[WIDTH*g +: WIDTH];
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (win_gnt),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        d_d         = '0;
        en_d        = '0;
        sr_d        = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        rsp_err_d   = rsp_err_q;
        req_ready_o = '0;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    req_ready_o = win_gnt;
                    id_d        = win_idx;
                    op_d        = op_arr[win_idx];
                    ptr_d       = (win_idx == IdxW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d     = StDrive;
                    // Drive vectors are registered so they appear exactly in DRIVE.
                    case (op_arr[win_idx])
                        OP_WRITE: begin
                            en_d = mask_arr[win_idx];
                            d_d  = data_arr[win_idx];
                        end
                        OP_RESET: sr_d = mask_arr[win_idx];
                        default: ;
                    endcase
                end
            end
            StDrive: begin
                cnt_d   = SettleCntW'(SETTLE - 1);
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_q_d     = bank_q_i;
                    rsp_err_d   = (op_q == OP_RSVD);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            id_q        <= '0;
            op_q        <= OP_READ;
            cnt_q       <= '0;
            d_q         <= '0;
            en_q        <= '0;
            sr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            en_q        <= en_d;
            sr_q        <= sr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bank_d_o    = d_q;
    assign bank_en_o   = en_q;
    assign bank_sr_o   = sr_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_q_o     = rsp_q_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != StIdle);

endmodule
